// File: rtl/lc3_memory_pkg.sv
// Shared constants and address decode for the LC-3 memory / memory-mapped I/O unit.
package lc3_memory_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CHAR_W = 8;

    localparam logic [WORD_W-1:0] ADDR_KBSR = 16'hFE00;
    localparam logic [WORD_W-1:0] ADDR_KBDR = 16'hFE02;
    localparam logic [WORD_W-1:0] ADDR_DSR  = 16'hFE04;
    localparam logic [WORD_W-1:0] ADDR_DDR  = 16'hFE06;

    typedef enum logic [2:0] {
        SRC_RAM,
        SRC_KBSR,
        SRC_KBDR,
        SRC_DSR,
        SRC_DDR,
        SRC_NONE
    } memSrc_t;

    // Classify an address; inRam is the caller's RAM range decode.
    function automatic memSrc_t decodeAddr(input logic [WORD_W-1:0] addr, input logic inRam);
        memSrc_t src;
        src = SRC_NONE;
        if (inRam) begin
            src = SRC_RAM;
        end else begin
            case (addr)
                ADDR_KBSR: src = SRC_KBSR;
                ADDR_KBDR: src = SRC_KBDR;
                ADDR_DSR:  src = SRC_DSR;
                ADDR_DDR:  src = SRC_DDR;
                default:   src = SRC_NONE;
            endcase
        end
        return src;
    endfunction

endpackage

// File: rtl/lc3_memory_ram.sv
// Word-addressed main RAM: asynchronous read, synchronous write, no reset.
module lc3_memory_ram #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    input  logic [15:0]                  wdata,
    output logic [15:0]                  rdata
);

    logic [15:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/lc3_memory.sv
// LC-3 memory unit: MAR/MDR, main RAM and the KBSR/KBDR/DSR/DDR device registers.
module lc3_memory
    import lc3_memory_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] busIn,
    input  logic              ldMAR,
    input  logic              ldMDR,
    input  logic              selMDR,
    input  logic              memWE,
    input  logic              enaMDR,
    output logic [WORD_W-1:0] mdrOut,
    input  logic              kbdValid,
    input  logic [CHAR_W-1:0] kbdData,
    output logic              kbdReady,
    output logic              ddrValid,
    output logic [CHAR_W-1:0] ddrData,
    input  logic              dispAck
);

    localparam int unsigned ADDR_W = $clog2(MEM_WORDS);

    logic [WORD_W-1:0] mar;
    logic [WORD_W-1:0] mdr;
    logic [CHAR_W-1:0] kbdr;
    logic              kbdFull;
    logic              dispReady;

    logic              ramHit;
    logic [ADDR_W-1:0] ramAddr;
    logic              ramWe;
    logic [WORD_W-1:0] ramData;
    memSrc_t           src;
    logic [WORD_W-1:0] readValue;
    logic              kbdRead;
    logic              ddrWrite;

    // RAM occupies x0000..MEM_WORDS-1; everything above is devices or unmapped.
    assign ramHit  = (mar[WORD_W-1:ADDR_W] == '0);
    assign ramAddr = ramHit ? mar[ADDR_W-1:0] : '0;
    assign ramWe   = memWE && ramHit;
    assign src     = decodeAddr(mar, ramHit);

    lc3_memory_ram #(
        .MEM_WORDS(MEM_WORDS)
    ) u_ram (
        .clk  (clk),
        .we   (ramWe),
        .addr (ramAddr),
        .wdata(mdr),
        .rdata(ramData)
    );

    // Read mux for the location currently addressed by MAR.
    always_comb begin
        readValue = '0;
        case (src)
            SRC_RAM:  readValue = ramData;
            SRC_KBSR: readValue = {kbdFull, 15'(0)};
            SRC_KBDR: readValue = {8'(0), kbdr};
            SRC_DSR:  readValue = {dispReady, 15'(0)};
            default:  readValue = '0;
        endcase
    end

    assign kbdRead  = ldMDR && selMDR && (src == SRC_KBDR);
    assign ddrWrite = memWE && (src == SRC_DDR) && dispReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            mar <= '0;
            mdr <= '0;
        end else begin
            if (ldMAR) begin
                mar <= busIn;
            end
            if (ldMDR) begin
                mdr <= selMDR ? readValue : busIn;
            end
        end
    end

    // A capture only happens while empty, so it can never collide with a KBDR read that empties.
    always_ff @(posedge clk) begin
        if (reset) begin
            kbdr    <= '0;
            kbdFull <= 1'b0;
        end else if (kbdValid && !kbdFull) begin
            kbdr    <= kbdData;
            kbdFull <= 1'b1;
        end else if (kbdRead) begin
            kbdFull <= 1'b0;
        end
    end

    // DDR writes are accepted only while the display is ready; otherwise dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            ddrValid  <= 1'b0;
            ddrData   <= '0;
            dispReady <= 1'b1;
        end else if (ddrWrite) begin
            ddrValid  <= 1'b1;
            ddrData   <= mdr[CHAR_W-1:0];
            dispReady <= 1'b0;
        end else if (ddrValid && dispAck) begin
            ddrValid  <= 1'b0;
            dispReady <= 1'b1;
        end
    end

    assign mdrOut   = enaMDR ? mdr : '0;
    assign kbdReady = ~kbdFull;

endmodule

// File: tb/tb_lc3_memory.sv
// Self-checking bench for lc3_memory: directed scenarios plus randomized traffic against a model.
module tb_lc3_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] busIn = '0;
    logic        ldMAR = 1'b0, ldMDR = 1'b0, selMDR = 1'b0, memWE = 1'b0, enaMDR = 1'b1;
    logic [15:0] mdrOut;
    logic        kbdValid = 1'b0;
    logic [7:0]  kbdData = '0;
    logic        kbdReady, ddrValid;
    logic [7:0]  ddrData;
    logic        dispAck = 1'b0;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] mMem [1024];
    logic [15:0] mMar, mMdr;
    logic [7:0]  mKbd, mDdrData;
    logic        mKbdFull, mDispReady, mDdrValid;

    lc3_memory #(.MEM_WORDS(1024)) dut (
        .clk(clk), .reset(reset), .busIn(busIn), .ldMAR(ldMAR), .ldMDR(ldMDR),
        .selMDR(selMDR), .memWE(memWE), .enaMDR(enaMDR), .mdrOut(mdrOut),
        .kbdValid(kbdValid), .kbdData(kbdData), .kbdReady(kbdReady),
        .ddrValid(ddrValid), .ddrData(ddrData), .dispAck(dispAck)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] modelRead(input logic [15:0] a);
        if (a < 16'd1024)      return mMem[a[9:0]];
        else if (a == 16'hFE00) return {mKbdFull, 15'd0};
        else if (a == 16'hFE02) return {8'd0, mKbd};
        else if (a == 16'hFE04) return {mDispReady, 15'd0};
        else                    return 16'h0000;
    endfunction

    // Apply one edge of behaviour to the model, using the inputs present at that edge.
    task automatic modelEdge();
        logic [15:0] rv, nMar, nMdr;
        logic        nFull, nReady, nValid;
        logic [7:0]  nKbd, nData;
        if (reset) begin
            mMar = 0; mMdr = 0; mKbd = 0; mKbdFull = 0;
            mDispReady = 1; mDdrValid = 0; mDdrData = 0;
            return;
        end
        rv = modelRead(mMar);
        nMar = ldMAR ? busIn : mMar;
        nMdr = ldMDR ? (selMDR ? rv : busIn) : mMdr;
        nKbd = mKbd; nFull = mKbdFull;
        if (kbdValid && !mKbdFull) begin
            nKbd = kbdData; nFull = 1;
        end else if (ldMDR && selMDR && mMar == 16'hFE02) begin
            nFull = 0;
        end
        nReady = mDispReady; nValid = mDdrValid; nData = mDdrData;
        if (mDdrValid && dispAck) begin
            nValid = 0; nReady = 1;
        end
        if (memWE) begin
            if (mMar < 16'd1024) mMem[mMar[9:0]] = mMdr;
            else if (mMar == 16'hFE06 && mDispReady) begin
                nData = mMdr[7:0]; nValid = 1; nReady = 0;
            end
        end
        mMar = nMar; mMdr = nMdr; mKbd = nKbd; mKbdFull = nFull;
        mDispReady = nReady; mDdrValid = nValid; mDdrData = nData;
    endtask

    task automatic tick(input logic a, input logic b, input logic c, input logic d,
                        input logic [15:0] bus);
        ldMAR = a; ldMDR = b; selMDR = c; memWE = d; busIn = bus;
        @(posedge clk);
        modelEdge();
        #1;
        ldMAR = 0; ldMDR = 0; selMDR = 0; memWE = 0;
    endtask

    task automatic setMar(input logic [15:0] a); tick(1, 0, 0, 0, a); endtask
    task automatic setMdr(input logic [15:0] v); tick(0, 1, 0, 0, v); endtask
    task automatic doWrite(); tick(0, 0, 0, 1, 16'h0); endtask
    task automatic doRead(); tick(0, 1, 1, 0, 16'h0); endtask

    task automatic test_reset();
        reset = 1;
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        reset = 0;
        enaMDR = 1;
        checks++; if (mdrOut !== 16'h0000) begin failures++; $display("FAIL reset_mdr got=%h exp=0000", mdrOut); end
        checks++; if (kbdReady !== 1'b1) begin failures++; $display("FAIL reset_kbdReady got=%b exp=1", kbdReady); end
        checks++; if (ddrValid !== 1'b0) begin failures++; $display("FAIL reset_ddrValid got=%b exp=0", ddrValid); end
        checks++; if (ddrData !== 8'h00) begin failures++; $display("FAIL reset_ddrData got=%h exp=00", ddrData); end
        enaMDR = 0;
        setMdr(16'hBEEF);
        checks++; if (mdrOut !== 16'h0000) begin failures++; $display("FAIL ena_low_gates got=%h exp=0000", mdrOut); end
        enaMDR = 1;
    endtask

    task automatic init_ram();
        logic [15:0] v;
        for (int i = 0; i < 1024; i++) begin
            v = 16'($urandom);
            if (v == 16'h1234) v = 16'h0000;
            setMar(16'(i));
            setMdr(v);
            doWrite();
        end
    endtask

    task automatic test_store_load();
        logic [15:0] exp11;
        setMar(16'h0010); setMdr(16'h1234); doWrite();
        setMdr(16'h0000);
        doRead();
        checks++; if (mdrOut !== 16'h1234) begin failures++; $display("FAIL store_load got=%h exp=1234", mdrOut); end
        exp11 = mMem[11'h011];
        setMar(16'h0011); doRead();
        checks++; if (mdrOut !== exp11 || mdrOut === 16'h1234) begin
            failures++; $display("FAIL unwritten_word got=%h exp=%h", mdrOut, exp11);
        end
    endtask

    task automatic test_unmapped();
        logic [15:0] exp0;
        exp0 = mMem[0];
        setMar(16'hC000); setMdr(16'h5555); doWrite(); doRead();
        checks++; if (mdrOut !== 16'h0000) begin failures++; $display("FAIL unmapped_read got=%h exp=0000", mdrOut); end
        setMar(16'h0400); setMdr(16'h7777); doWrite(); doRead();
        checks++; if (mdrOut !== 16'h0000) begin failures++; $display("FAIL above_ram_read got=%h exp=0000", mdrOut); end
        setMar(16'h0000); doRead();
        checks++; if (mdrOut !== exp0) begin failures++; $display("FAIL ram0_intact got=%h exp=%h", mdrOut, exp0); end
    endtask

    task automatic test_keyboard();
        kbdValid = 1; kbdData = 8'h41;
        tick(0, 0, 0, 0, 0);
        kbdValid = 0;
        checks++; if (kbdReady !== 1'b0) begin failures++; $display("FAIL kbd_full got=%b exp=0", kbdReady); end
        setMar(16'hFE00); doRead();
        checks++; if (mdrOut !== 16'h8000) begin failures++; $display("FAIL kbsr_full got=%h exp=8000", mdrOut); end
        kbdValid = 1; kbdData = 8'h42;
        tick(0, 0, 0, 0, 0);
        kbdValid = 0;
        setMar(16'hFE02); doRead();
        checks++; if (mdrOut !== 16'h0041) begin failures++; $display("FAIL kbdr_read got=%h exp=0041", mdrOut); end
        checks++; if (kbdReady !== 1'b1) begin failures++; $display("FAIL kbd_drained got=%b exp=1", kbdReady); end
        setMar(16'hFE00); doRead();
        checks++; if (mdrOut !== 16'h0000) begin failures++; $display("FAIL kbsr_empty got=%h exp=0000", mdrOut); end
    endtask

    task automatic test_display();
        setMdr(16'h0048); setMar(16'hFE06); doWrite();
        checks++; if (ddrValid !== 1'b1 || ddrData !== 8'h48) begin
            failures++; $display("FAIL ddr_write got=%b/%h exp=1/48", ddrValid, ddrData);
        end
        setMar(16'hFE04); doRead();
        checks++; if (mdrOut !== 16'h0000) begin failures++; $display("FAIL dsr_busy got=%h exp=0000", mdrOut); end
        setMdr(16'h0049); setMar(16'hFE06); doWrite();
        checks++; if (ddrValid !== 1'b1 || ddrData !== 8'h48) begin
            failures++; $display("FAIL ddr_drop got=%b/%h exp=1/48", ddrValid, ddrData);
        end
        setMar(16'hFE06); doRead();
        checks++; if (mdrOut !== 16'h0000) begin failures++; $display("FAIL ddr_readback got=%h exp=0000", mdrOut); end
        dispAck = 1;
        tick(0, 0, 0, 0, 0);
        dispAck = 0;
        checks++; if (ddrValid !== 1'b0) begin failures++; $display("FAIL ddr_ack got=%b exp=0", ddrValid); end
        setMar(16'hFE04); doRead();
        checks++; if (mdrOut !== 16'h8000) begin failures++; $display("FAIL dsr_ready got=%h exp=8000", mdrOut); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp0;
        setMar(16'h0030); setMdr(16'hABCD); doWrite();
        setMdr(16'h0055); setMar(16'hFE06); doWrite();
        kbdValid = 1; kbdData = 8'h61;
        tick(0, 0, 0, 0, 0);
        kbdValid = 0;
        checks++; if (ddrValid !== 1'b1 || kbdReady !== 1'b0) begin
            failures++; $display("FAIL pre_reset got=%b/%b exp=1/0", ddrValid, kbdReady);
        end
        reset = 1;
        tick(0, 0, 0, 0, 0);
        reset = 0;
        checks++; if (ddrValid !== 1'b0 || kbdReady !== 1'b1 || mdrOut !== 16'h0000) begin
            failures++; $display("FAIL mid_reset got=%b/%b/%h exp=0/1/0000", ddrValid, kbdReady, mdrOut);
        end
        exp0 = mMem[0];
        doRead();
        checks++; if (mdrOut !== exp0) begin failures++; $display("FAIL mar_reset got=%h exp=%h", mdrOut, exp0); end
        setMar(16'hFE04); doRead();
        checks++; if (mdrOut !== 16'h8000) begin failures++; $display("FAIL dsr_after_reset got=%h exp=8000", mdrOut); end
        setMar(16'h0030); doRead();
        checks++; if (mdrOut !== 16'hABCD) begin failures++; $display("FAIL ram_survives got=%h exp=abcd", mdrOut); end
    endtask

    task automatic test_same_cycle();
        logic [15:0] exp20;
        setMar(16'h0010);
        tick(1, 1, 1, 0, 16'h0020);
        checks++; if (mdrOut !== 16'h1234) begin failures++; $display("FAIL mar_mdr_same got=%h exp=1234", mdrOut); end
        exp20 = mMem[32];
        doRead();
        checks++; if (mdrOut !== exp20) begin failures++; $display("FAIL new_mar_read got=%h exp=%h", mdrOut, exp20); end
    endtask

    task automatic test_back_to_back();
        setMar(16'h0040); setMdr(16'h1111);
        tick(0, 1, 0, 1, 16'h2222);
        checks++; if (mdrOut !== 16'h2222) begin failures++; $display("FAIL mdr_we_new got=%h exp=2222", mdrOut); end
        doRead();
        checks++; if (mdrOut !== 16'h1111) begin failures++; $display("FAIL mdr_we_old got=%h exp=1111", mdrOut); end
    endtask

    task automatic test_random();
        logic [15:0] pool [8];
        logic [15:0] bus;
        for (int n = 0; n < 600; n++) begin
            pool[0] = 16'($urandom_range(0, 1023)); pool[1] = 16'hFE00; pool[2] = 16'hFE02;
            pool[3] = 16'hFE04; pool[4] = 16'hFE06; pool[5] = 16'hC000;
            pool[6] = 16'h0400; pool[7] = 16'($urandom_range(0, 63));
            bus = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : 16'($urandom);
            kbdValid = ($urandom_range(0, 9) < 3);
            kbdData  = 8'($urandom);
            dispAck  = ($urandom_range(0, 9) < 3);
            enaMDR   = ($urandom_range(0, 3) != 0);
            reset    = ($urandom_range(0, 99) == 0);
            tick($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, bus);
            reset = 0;
            checks++; if (mdrOut !== (enaMDR ? mMdr : 16'h0000)) begin
                failures++; $display("FAIL rand_mdr n=%0d got=%h exp=%h", n, mdrOut, enaMDR ? mMdr : 16'h0000);
            end
            checks++; if (kbdReady !== !mKbdFull) begin
                failures++; $display("FAIL rand_kbdReady n=%0d got=%b exp=%b", n, kbdReady, !mKbdFull);
            end
            checks++; if (ddrValid !== mDdrValid || ddrData !== mDdrData) begin
                failures++; $display("FAIL rand_ddr n=%0d got=%b/%h exp=%b/%h", n, ddrValid, ddrData, mDdrValid, mDdrData);
            end
        end
        kbdValid = 0; dispAck = 0; enaMDR = 1;
    endtask

    initial begin
        test_reset();
        init_ram();
        test_store_load();
        test_unmapped();
        test_keyboard();
        test_display();
        test_reset_mid();
        test_same_cycle();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
